pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-flow controller sitting directly upstream of the text overlay stage.
//  Owns the Pong session state: 2-digit BCD score, balls remaining, and the
//  newgame/play/newball/over state machine with a frame-tick countdown timer.
//  Drives the overlay's score digits, ball count and per-region text enables,
//  and freezes the graphics engine between rallies.
// PARAMETERS
//  BALLS         3    balls per game (1..3); loaded into ball on new game
//  TIMER_FRAMES  120  countdown length in refr_tick pulses (2 s at 60 Hz)
//  TIMER_W       7    timer width; must hold TIMER_FRAMES-1
// PORTS
//  clk        in   1  system clock; sole clock domain
//  reset_n    in   1  synchronous reset, active low
//  refr_tick  in   1  one-cycle pulse per video frame (start of vsync)
//  btn        in   2  player buttons, already debounced, level
//  hit        in   1  one-cycle pulse: paddle returned ball
//  miss       in   1  one-cycle pulse: ball passed paddle
//  dig0       out  4  score units, BCD 0..9
//  dig1       out  4  score tens, BCD 0..9
//  ball       out  2  balls remaining, binary
//  text_sel   out  4  region enables {score,logo,rule,over}, same order as overlay text_on
//  gra_still  out  1  1 = hold ball/paddle motion (ball parked at centre)
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge, any state): state=NEWGAME, dig1/dig0=0/0,
//   ball=BALLS, timer=0, gra_still=1, text_sel=4'b1110. Mid-game reset discards
//   score, balls and pending timer in the same edge.
//  All outputs are registered; an input event is visible one cycle later.
//  Timer: load TIMER_FRAMES-1 on timer_start; else decrement on refr_tick while
//   nonzero; timer_done = (timer==0). A load takes priority over a tick in the same cycle.
//  FSM (encoded in package):
//   NEWGAME: gra_still=1, text_sel=1110. dig cleared, ball=BALLS held.
//     btn!=0 -> PLAY, ball<=ball-1.
//   PLAY: gra_still=0, text_sel=1000. hit -> score+1.
//     miss & ball==0 -> OVER, timer_start. miss & ball!=0 -> NEWBALL,
//     ball<=ball-1, timer_start.
//   NEWBALL: gra_still=1, text_sel=1000. timer_done & btn!=0 -> PLAY.
//     Buttons are ignored while timer is nonzero.
//   OVER: gra_still=1, text_sel=1001. timer_done -> NEWGAME (clears score,
//     reloads ball on entry).
//  Score: 2-digit BCD increment; dig0 9->0 carries into dig1; 99 wraps to 00.
//   Never leaves BCD range. Clear has priority over increment.
//  hit and miss in the same PLAY cycle: score increments AND miss transition
//   is taken. hit/miss outside PLAY are ignored.
//  ball never underflows: decrement only when the transition above fires.
//  btn held across OVER->NEWGAME does not skip NEWGAME; a fresh press is required
//   (edge-detect btn!=0, register 1 bit).
// STRUCTURE
//  pong_pkg: state enum (NEWGAME, PLAY, NEWBALL, OVER), TXT_SCORE/LOGO/RULE/OVER
//   bit indices, BCD digit typedef.
//  Sub-module pong_bcd_counter: 2-digit BCD, inputs clr/inc, outputs dig1/dig0;
//   instantiated once. FSM, timer, ball counter and button edge logic stay in this block.
// TESTING
//  1 Reset mid-PLAY with score 37, ball 1 -> next cycle: dig=00, ball=3, NEWGAME, text_sel=1110.
//  2 NEWGAME, btn=01 one cycle -> PLAY, ball=2, gra_still=0; 12 hit pulses -> dig1=1, dig0=2.
//  3 Score 99 + hit -> 00; 09 + hit -> 10; hit and miss same cycle at 45, ball 2 -> 46, ball 1, NEWBALL.
//  4 NEWBALL: btn held during countdown -> stays; after 120 refr_ticks + btn -> PLAY.
//  5 PLAY, ball=0, miss -> OVER, text_sel=1001; after 120 ticks -> NEWGAME, ball=3, dig=00;
//    btn held throughout does not start a new game.
//  6 refr_tick coincident with timer_start -> timer = 119, not 118.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the Pong game-flow controller
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_e;

  // Bit positions inside text_sel, matching the overlay's text_on ordering
  localparam int TXT_SCORE = 3;
  localparam int TXT_LOGO  = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  typedef logic [3:0] bcd_t;

  // Overlay regions shown in each game state; the score is always visible
  function automatic logic [3:0] text_sel_of(input state_e s);
    logic [3:0] t;
    t = '0;
    t[TXT_SCORE] = 1'b1;
    case (s)
      NEWGAME: begin
        t[TXT_LOGO] = 1'b1;
        t[TXT_RULE] = 1'b1;
      end
      OVER:    t[TXT_OVER] = 1'b1;
      default: t = t;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// rtl/pong_bcd_counter.sv - two-digit BCD score counter with clear and increment
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t dig1_o,
  output bcd_t dig0_o
);

  bcd_t dig1_q;
  bcd_t dig0_q;

  // Clear wins over increment; units carry into tens and 99 rolls to 00
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dig1_q <= '0;
      dig0_q <= '0;
    end else if (clr_i) begin
      dig1_q <= '0;
      dig0_q <= '0;
    end else if (inc_i) begin
      if (dig0_q == 4'd9) begin
        dig0_q <= '0;
        dig1_q <= (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_q <= dig0_q + 4'd1;
      end
    end
  end

  assign dig1_o = dig1_q;
  assign dig0_o = dig0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong session FSM, balls, countdown timer and overlay enables
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS        = 3,
  parameter int TIMER_FRAMES = 120,
  parameter int TIMER_W      = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic [3:0] text_sel,
  output logic       gra_still
);

  localparam logic [1:0]         BALLS_INIT = 2'(BALLS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_FRAMES - 1);

  state_e             state_q, state_d;
  logic [1:0]         ball_q, ball_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               btn_prev_q;
  logic [3:0]         text_sel_q;
  logic               gra_still_q;

  logic btn_any;
  logic btn_rise;
  logic timer_done;
  logic timer_start;
  logic score_clr;
  logic score_inc;

  assign btn_any    = |btn;
  assign btn_rise   = btn_any & ~btn_prev_q;
  assign timer_done = (timer_q == '0);

  // Next-state decode: transitions, ball bookkeeping, score and timer requests
  always_comb begin
    state_d     = state_q;
    ball_d      = ball_q;
    timer_start = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    case (state_q)
      NEWGAME: begin
        score_clr = 1'b1;
        // A fresh press is needed so a button held through game over cannot restart play
        if (btn_rise) begin
          state_d = PLAY;
          ball_d  = ball_q - 2'd1;
        end
      end
      PLAY: begin
        score_inc = hit;
        if (miss) begin
          timer_start = 1'b1;
          if (ball_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = NEWBALL;
            ball_d  = ball_q - 2'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_done && btn_any) begin
          state_d = PLAY;
        end
      end
      OVER: begin
        if (timer_done) begin
          state_d   = NEWGAME;
          score_clr = 1'b1;
          ball_d    = BALLS_INIT;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Countdown: a load beats a same-cycle frame tick; otherwise count down to zero
  always_comb begin
    timer_d = timer_q;
    if (timer_start) begin
      timer_d = TIMER_LOAD;
    end else if (refr_tick && !timer_done) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  // State, counters and registered overlay outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= NEWGAME;
      ball_q      <= BALLS_INIT;
      timer_q     <= '0;
      btn_prev_q  <= 1'b0;
      text_sel_q  <= text_sel_of(NEWGAME);
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ball_q      <= ball_d;
      timer_q     <= timer_d;
      btn_prev_q  <= btn_any;
      text_sel_q  <= text_sel_of(state_d);
      gra_still_q <= (state_d != PLAY);
    end
  end

  pong_bcd_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .dig1_o  (dig1),
    .dig0_o  (dig0)
  );

  assign ball      = ball_q;
  assign text_sel  = text_sel_q;
  assign gra_still = gra_still_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl against a game model
module tb_pong_game_ctrl;

  localparam int BALLS  = 3;
  localparam int FRAMES = 120;

  localparam int M_NEW  = 0;
  localparam int M_PLAY = 1;
  localparam int M_WAIT = 2;
  localparam int M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] dig0, dig1;
  logic [1:0] ball;
  logic [3:0] text_sel;
  logic       gra_still;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference game state: score as plain integer, countdown as frames left
  int m_mode  = M_NEW;
  int m_score = 0;
  int m_balls = BALLS;
  int m_timer = 0;
  int m_prev  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALLS(BALLS), .TIMER_FRAMES(FRAMES), .TIMER_W(7)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .refr_tick (refr_tick),
    .btn       (btn),
    .hit       (hit),
    .miss      (miss),
    .dig0      (dig0),
    .dig1      (dig1),
    .ball      (ball),
    .text_sel  (text_sel),
    .gra_still (gra_still)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_text(input int mode);
    case (mode)
      M_NEW:   return 4'b1110;
      M_OVER:  return 4'b1001;
      default: return 4'b1000;
    endcase
  endfunction

  // Apply the game rules for one clock edge, using the inputs held at that edge
  task automatic model_step();
    int any, done, start, nxt;
    if (!reset_n) begin
      m_mode = M_NEW; m_score = 0; m_balls = BALLS; m_timer = 0; m_prev = 0;
      return;
    end
    any   = (btn != 2'b00) ? 1 : 0;
    done  = (m_timer == 0) ? 1 : 0;
    start = 0;
    nxt   = m_mode;
    if (m_mode == M_NEW) begin
      m_score = 0;
      if (any == 1 && m_prev == 0) begin nxt = M_PLAY; m_balls = m_balls - 1; end
    end else if (m_mode == M_PLAY) begin
      if (hit) m_score = (m_score + 1) % 100;
      if (miss) begin
        start = 1;
        if (m_balls == 0) nxt = M_OVER;
        else begin nxt = M_WAIT; m_balls = m_balls - 1; end
      end
    end else if (m_mode == M_WAIT) begin
      if (done == 1 && any == 1) nxt = M_PLAY;
    end else begin
      if (done == 1) begin nxt = M_NEW; m_score = 0; m_balls = BALLS; end
    end
    if (start == 1) m_timer = FRAMES - 1;
    else if (refr_tick && m_timer > 0) m_timer = m_timer - 1;
    m_prev = any;
    m_mode = nxt;
  endtask

  task automatic check_all();
    chk("dig1", dig1, m_score / 10);
    chk("dig0", dig0, m_score % 10);
    chk("ball", ball, m_balls);
    chk("text_sel", text_sel, exp_text(m_mode));
    chk("gra_still", gra_still, (m_mode == M_PLAY) ? 0 : 1);
  endtask

  task automatic step(input logic r, input logic t, input logic [1:0] b,
                      input logic h, input logic m);
    reset_n = r; refr_tick = t; btn = b; hit = h; miss = m;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n, input logic [1:0] b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    chk("rst_text", text_sel, 4'b1110);
    chk("rst_ball", ball, 3);
    chk("rst_still", gra_still, 1);
    idle(3);

    // Start a game and score twelve
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("start_ball", ball, 2);
    chk("start_still", gra_still, 0);
    idle(1);
    hits(12);
    chk("s12_dig1", dig1, 1);
    chk("s12_dig0", dig0, 2);

    // Wrap 99 -> 00, carry 09 -> 10, then hit with miss at 45
    hits(87);
    chk("s99_dig1", dig1, 9);
    hits(1);
    chk("wrap_dig", {dig1, dig0}, 8'h00);
    hits(10);
    chk("carry_dig", {dig1, dig0}, 8'h10);
    hits(35);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    chk("hm_dig", {dig1, dig0}, 8'h46);
    chk("hm_ball", ball, 1);
    chk("hm_still", gra_still, 1);

    // Buttons ignored while the countdown runs
    ticks(30, 2'b01);
    chk("nb_hold_still", gra_still, 1);
    ticks(FRAMES, 2'b00);
    idle(2);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("nb_play_still", gra_still, 0);
    idle(1);

    // Mid-play reset at score 37 with one ball left
    hits(91);
    chk("pre_rst_dig", {dig1, dig0}, 8'h37);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("mid_rst_dig", {dig1, dig0}, 8'h00);
    chk("mid_rst_ball", ball, 3);
    chk("mid_rst_text", text_sel, 4'b1110);
    idle(2);

    // Burn all balls, last miss coincides with a frame tick
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      hits(3);
      step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      ticks(FRAMES, 2'b00);
      step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      idle(1);
    end
    chk("last_ball", ball, 0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    chk("over_text", text_sel, 4'b1001);
    ticks(FRAMES - 1, 2'b11);
    chk("over_still_text", text_sel, 4'b1001);
    step(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("ng_text", text_sel, 4'b1110);
    chk("ng_ball", ball, 3);
    chk("ng_dig", {dig1, dig0}, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("ng_held_still", gra_still, 1);
    idle(1);
    step(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    chk("ng_fresh_still", gra_still, 0);

    // Randomized play against the model
    for (int i = 0; i < 8000; i++) begin
      logic r, t, h, m;
      logic [1:0] b;
      r = ($urandom_range(0, 799) != 0);
      t = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      h = ($urandom_range(0, 5) == 0);
      m = ($urandom_range(0, 19) == 0);
      step(r, t, b, h, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
